if_prefetch: RTL and testbench

Instruction fetch front end of the RISC-V core. Generates the sequential fetch PC, issues requests on the instruction bus, and buffers returned instructions in a small FIFO. It presents one instruction per cycle, with its address, to the IF/ID pipeline register. Jumps from execute flush the buffer and discard in-flight responses.

---
 rtl/if_prefetch_pkg.sv | 11 +
 rtl/if_fifo.sv | 59 +++++
 rtl/if_prefetch.sv | 98 +++++++++
 tb/tb_if_prefetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// rtl/if_prefetch_pkg.sv - shared constants for the instruction fetch front end
package if_prefetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - prefetch instruction FIFO with flush, count and registered head word
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // push and pop on a full FIFO share a slot: head moves off it as it is rewritten
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

    assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && !flush && count == CW'(DEPTH)));

    assert property (@(posedge clk) disable iff (!rst)
        !(pop && !flush && count == '0));

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - sequential PC generator, credit-limited bus requester and prefetch buffer
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int            DW       = ADDR_W,
    parameter int            DEPTH    = 2,
    parameter logic [DW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_flag_i,
    input  logic [DW-1:0] jump_addr_i,
    input  logic          hold_flag_i,
    output logic          ibus_req_o,
    output logic [DW-1:0] ibus_addr_o,
    input  logic          ibus_gnt_i,
    input  logic          ibus_rvalid_i,
    input  logic [DW-1:0] ibus_rdata_i,
    output logic [DW-1:0] inst_o,
    output logic [DW-1:0] inst_addr_o,
    output logic          inst_valid_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    logic [DW-1:0] fetch_pc;
    logic [DW-1:0] head_pc;
    logic [CW-1:0] occ;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [DW-1:0] fifo_head;
    logic [SW-1:0] credit_used;
    logic          pop;
    logic          push;
    logic          grant;

    assign inst_valid_o = (occ != '0);
    assign pop          = inst_valid_o & ~hold_flag_i & ~jump_flag_i;

    // buffered plus outstanding words, counting this cycle's pop as already freed
    assign credit_used  = {1'b0, occ} + {1'b0, inflight} - SW'(pop);
    assign ibus_req_o   = rst & ~jump_flag_i & (credit_used < SW'(DEPTH));
    assign ibus_addr_o  = fetch_pc;
    assign grant        = ibus_req_o & ibus_gnt_i;
    assign push         = ibus_rvalid_i & ~jump_flag_i & (drop == '0);

    assign inst_o       = inst_valid_o ? fifo_head : DW'(NOP_INST);
    assign inst_addr_o  = head_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(grant) - CW'(ibus_rvalid_i);
            if (jump_flag_i) begin
                fetch_pc <= jump_addr_i;
                head_pc  <= jump_addr_i;
                // everything still outstanding after this cycle belongs to the old stream
                drop     <= inflight - CW'(ibus_rvalid_i);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + DW'(PC_STEP);
                end
                if (pop) begin
                    head_pc <= head_pc + DW'(PC_STEP);
                end
                if (ibus_rvalid_i && drop != '0) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ibus_rdata_i),
        .pop       (pop),
        .flush     (jump_flag_i),
        .count     (occ),
        .head      (fifo_head)
    );

    assert property (@(posedge clk) disable iff (!rst)
        ibus_rvalid_i |-> (inflight != '0));

    assert property (@(posedge clk) disable iff (!rst)
        drop <= inflight);

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - randomized and directed bench for if_prefetch against a queue model
module tb_if_prefetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        hold_flag = 1'b0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt = 1'b0;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;

    always #5 clk = ~clk;

    if_prefetch #(.DW(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .hold_flag_i   (hold_flag),
        .ibus_req_o    (ibus_req),
        .ibus_addr_o   (ibus_addr),
        .ibus_gnt_i    (ibus_gnt),
        .ibus_rvalid_i (ibus_rvalid),
        .ibus_rdata_i  (ibus_rdata),
        .inst_o        (inst),
        .inst_addr_o   (inst_addr),
        .inst_valid_o  (inst_valid)
    );

    typedef struct { logic [31:0] addr; logic stale; } out_t;
    typedef struct { logic [31:0] addr; int rdy; } bus_t;

    out_t        out_q[$];
    logic [31:0] fifo_q[$];
    bus_t        bus_q[$];
    logic [31:0] m_fetch, m_head;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, last_rdy = 0;
    int gnt_pct = 100, rv_pct = 100, lat_min = 1, lat_max = 1;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hDEAD_0003;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_bus(input int g, input int r, input int lmin, input int lmax);
        gnt_pct = g; rv_pct = r; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        hold_flag = 1'b0; jump_flag = 1'b0; jump_addr = '0;
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
        #1;
        check("rst_req", ibus_req, 0);
        check("rst_addr", ibus_addr, 0);
        check("rst_inst", inst, NOP);
        check("rst_inst_addr", inst_addr, 0);
        check("rst_valid", inst_valid, 0);
        bus_q.delete(); out_q.delete(); fifo_q.delete();
        m_fetch = '0; m_head = '0; last_rdy = 0;
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    task automatic step(input logic h, input logic j, input logic [31:0] ja);
        logic rv, m_pop, m_req;
        int   rdy;
        out_t e;
        @(posedge clk);
        #1;
        cyc++;
        hold_flag = h; jump_flag = j; jump_addr = ja;
        ibus_gnt  = ($urandom_range(99) < gnt_pct);
        rv = (bus_q.size() > 0) && (bus_q[0].rdy <= cyc) && ($urandom_range(99) < rv_pct);
        ibus_rvalid = rv;
        ibus_rdata  = rv ? dat(bus_q[0].addr) : $urandom;
        #1;
        m_pop = (fifo_q.size() > 0) && !h && !j;
        m_req = !j && (fifo_q.size() + out_q.size() - (m_pop ? 1 : 0) < DEPTH);
        check("req", ibus_req, m_req);
        check("addr", ibus_addr, m_fetch);
        check("valid", inst_valid, fifo_q.size() > 0);
        check("inst", inst, (fifo_q.size() > 0) ? dat(fifo_q[0]) : NOP);
        check("inst_addr", inst_addr, m_head);
        // bus environment
        if (rv) void'(bus_q.pop_front());
        if (ibus_req && ibus_gnt) begin
            rdy = cyc + $urandom_range(lat_max, lat_min);
            if (rdy < last_rdy) rdy = last_rdy;
            last_rdy = rdy;
            bus_q.push_back('{ibus_addr, rdy});
        end
        // reference model
        if (j) begin
            fifo_q.delete();
            foreach (out_q[i]) out_q[i].stale = 1'b1;
            if (rv && out_q.size() > 0) void'(out_q.pop_front());
            m_fetch = ja; m_head = ja;
        end else begin
            if (m_pop) begin
                void'(fifo_q.pop_front());
                m_head += 32'd4;
            end
            if (rv && out_q.size() > 0) begin
                e = out_q.pop_front();
                if (!e.stale) fifo_q.push_back(e.addr);
            end
            if (m_req && ibus_gnt) begin
                out_q.push_back('{m_fetch, 1'b0});
                m_fetch += 32'd4;
            end
        end
    endtask

    initial begin
        logic seen;
        logic [31:0] ja;
        #2;

        // streaming after reset release, zero-wait bus
        set_bus(100, 100, 1, 1);
        apply_reset();
        step(0, 0, 0); check("t1_req", ibus_req, 1); check("t1_addr0", ibus_addr, 32'h0);
        step(0, 0, 0); check("t1_addr1", ibus_addr, 32'h4); check("t1_novalid", inst_valid, 0);
        step(0, 0, 0); check("t1_valid", inst_valid, 1); check("t1_ia0", inst_addr, 32'h0);
        check("t1_inst0", inst, 32'hDEAD_0003);
        step(0, 0, 0); check("t1_ia1", inst_addr, 32'h4);
        repeat (6) step(0, 0, 0);

        // hold for five cycles after two fetches
        apply_reset();
        step(0, 0, 0); step(0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0);
            check("t2_req_off", ibus_req, 0);
            check("t2_ia_frozen", inst_addr, 32'h0);
        end
        step(0, 0, 0); check("t2_ia0", inst_addr, 32'h0);
        step(0, 0, 0); check("t2_ia4", inst_addr, 32'h4);
        step(0, 0, 0); check("t2_ia8", inst_addr, 32'h8);
        repeat (4) step(0, 0, 0);

        // jump with two responses in flight, 3-cycle bus
        apply_reset();
        set_bus(100, 100, 3, 3);
        step(0, 0, 0); step(0, 0, 0);
        step(0, 1, 32'h100);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(0, 0, 0);
            seen = inst_valid;
        end
        check("t3_seen", seen, 1);
        check("t3_ia", inst_addr, 32'h100);
        check("t3_inst", inst, 32'hDEAD_0103);

        // jump coinciding with rvalid and hold
        set_bus(100, 100, 1, 1);
        apply_reset();
        step(0, 0, 0); step(0, 0, 0);
        step(1, 1, 32'h200);
        step(0, 0, 0);
        check("t4_valid", inst_valid, 0); check("t4_inst", inst, NOP);
        check("t4_ia", inst_addr, 32'h200); check("t4_addr", ibus_addr, 32'h200);
        step(0, 0, 0); step(0, 0, 0);
        check("t4_tgt_valid", inst_valid, 1); check("t4_tgt_ia", inst_addr, 32'h200);

        // PC wrap
        apply_reset();
        step(0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0); check("t5_top", ibus_addr, 32'hFFFF_FFFC);
        step(0, 0, 0); check("t5_wrap", ibus_addr, 32'h0);
        repeat (3) step(0, 0, 0);

        // asynchronous reset with a full FIFO
        apply_reset();
        step(0, 0, 0); step(0, 0, 0); step(1, 0, 0); step(1, 0, 0);
        check("t6_full_valid", inst_valid, 1);
        apply_reset();

        // randomized traffic
        set_bus(70, 70, 1, 4);
        for (int n = 0; n < 3000; n++) begin
            ja = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2))
                                          : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(99) < 30, $urandom_range(99) < 5, ja);
            if (n == 1500) apply_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
